// File: rtl/univ_shift_reg.sv
// univ_shift_reg
// ---------------------------------------------------------------------------
// Parametrised universal shift register with a self-timed serialise burst.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   en         clock enable; 0 freezes q, FSM, counter and busy, clears done
//   mode[2:0]  operation select, applied when idle, en=1 and start=0
//   sin_l      serial input entering at the MSB on right-moving operations
//   sin_r      serial input entering at the LSB on left-moving operations
//   d          parallel load data (mode load and burst start)
//   start      burst request, sampled when idle and en=1
//   q          register contents
//   sout_lsb   q[0] (burst serial output, LSB first)
//   sout_msb   q[WIDTH-1]
//   busy       high while a burst is in progress
//   done       one-cycle pulse after the last burst bit
//   dbg_state  current FSM state (0 = IDLE, 1 = SHIFT)
//
// Burst handshake: start is a request, not a valid/ready pair. It is
// accepted on any enabled edge where the FSM is IDLE (including the cycle in
// which done is high); the accepting edge loads d and raises busy. While busy
// is high start, mode and d are ignored and a start is dropped, never queued.
// done pulses for exactly one enabled cycle after the last bit has been
// presented on sout_lsb.
// ---------------------------------------------------------------------------
module univ_shift_reg #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             sout_lsb,
  output logic             sout_msb,
  output logic             busy,
  output logic             done,
  output logic             dbg_state
);

  localparam int unsigned        CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_SHR   = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_LOAD  = 3'b011;
  localparam logic [2:0] M_ROTR  = 3'b100;
  localparam logic [2:0] M_ROTL  = 3'b101;
  localparam logic [2:0] M_ASR   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    // done is a pulse: it drops on every edge unless the burst ends here,
    // which also covers the en=0 case.
    done_d  = 1'b0;

    if (en) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            q_d     = d;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            case (mode)
              M_HOLD:  q_d = q_q;
              M_SHR:   q_d = {sin_l, q_q[WIDTH-1:1]};
              M_SHL:   q_d = {q_q[WIDTH-2:0], sin_r};
              M_LOAD:  q_d = d;
              M_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
              M_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
              M_ASR:   q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
              M_CLEAR: q_d = '0;
              default: q_d = q_q;
            endcase
          end
        end
        SHIFT: begin
          // The last bit is already on sout_lsb when cnt reaches LAST, so
          // this edge only closes the burst instead of shifting again.
          if (cnt_q == LAST) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            q_d   = {sin_l, q_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= RESET_VAL;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q         = q_q;
  assign sout_lsb  = q_q[0];
  assign sout_msb  = q_q[WIDTH-1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = (state_q == SHIFT);

endmodule

// File: tb/tb_univ_shift_reg.sv
module tb_univ_shift_reg;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         en;
  logic [2:0]   mode;
  logic         sin_l;
  logic         sin_r;
  logic [W-1:0] d;
  logic         start;
  logic [W-1:0] q;
  logic         sout_lsb;
  logic         sout_msb;
  logic         busy;
  logic         done;
  logic         dbg_state;

  int checks = 0;
  int errors = 0;

  univ_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sin_l     (sin_l),
    .sin_r     (sin_r),
    .d         (d),
    .start     (start),
    .q         (q),
    .sout_lsb  (sout_lsb),
    .sout_msb  (sout_msb),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; mode = 3'b011; d = 8'h5A;
    sin_l = 1'b0; sin_r = 1'b0; start = 1'b0;
    tick(); tick();
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: q=%h busy=%b done=%b, want q=00 busy=0 done=0", q, busy, done);
    end
    #2 reset = 1'b1;
    d = 8'hA5; mode = 3'b011;
    tick();
    checks++;
    if (q !== 8'hA5) begin
      errors++;
      $display("FAIL load_after_reset: q=%h want a5", q);
    end
    checks++;
    if (sout_lsb !== 1'b1 || sout_msb !== 1'b1) begin
      errors++;
      $display("FAIL sout_taps: lsb=%b msb=%b want 1 1", sout_lsb, sout_msb);
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] exp_r [4] = '{8'hD2, 8'hE9, 8'hF4, 8'hFA};
    mode = 3'b001; sin_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (q !== exp_r[i]) begin
        errors++;
        $display("FAIL shift_right[%0d]: q=%h want %h", i, q, exp_r[i]);
      end
    end
    mode = 3'b010; sin_r = 1'b0;
    tick(); tick();
    checks++;
    if (q !== 8'hE8) begin
      errors++;
      $display("FAIL shift_left: q=%h want e8", q);
    end
    mode = 3'b010; sin_r = 1'b1;
    tick();
    checks++;
    if (q !== 8'hD1) begin
      errors++;
      $display("FAIL shift_left_sin_r: q=%h want d1", q);
    end
  endtask

  task automatic test_rotate_asr_clear();
    mode = 3'b011; d = 8'h81; tick();
    mode = 3'b100; tick();
    checks++;
    if (q !== 8'hC0) begin
      errors++;
      $display("FAIL rotate_right: q=%h want c0", q);
    end
    mode = 3'b101; tick(); tick();
    checks++;
    if (q !== 8'h03) begin
      errors++;
      $display("FAIL rotate_left: q=%h want 03", q);
    end
    mode = 3'b011; d = 8'h90; tick();
    mode = 3'b110; tick();
    checks++;
    if (q !== 8'hC8) begin
      errors++;
      $display("FAIL asr: q=%h want c8", q);
    end
    mode = 3'b000; tick();
    checks++;
    if (q !== 8'hC8) begin
      errors++;
      $display("FAIL hold: q=%h want c8", q);
    end
    en = 1'b0; mode = 3'b111; tick();
    checks++;
    if (q !== 8'hC8) begin
      errors++;
      $display("FAIL en_low_hold: q=%h want c8", q);
    end
    en = 1'b1; tick();
    checks++;
    if (q !== 8'h00) begin
      errors++;
      $display("FAIL clear: q=%h want 00", q);
    end
    mode = 3'b000;
  endtask

  // Runs a full burst of 'word' starting from IDLE, checking every bit.
  task automatic run_burst(input logic [W-1:0] word, input string tag);
    d = word; start = 1'b1; sin_l = 1'b0; mode = 3'b000;
    tick();
    start = 1'b0; d = 8'hFF;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (sout_lsb !== word[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s_bit%0d: sout=%b busy=%b done=%b want sout=%b busy=1 done=0",
                 tag, i, sout_lsb, busy, done, word[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || q !== {7'b0, word[W-1]}) begin
      errors++;
      $display("FAIL %s_done: done=%b busy=%b q=%h want done=1 busy=0 q=%h",
               tag, done, busy, q, {7'b0, word[W-1]});
    end
  endtask

  task automatic test_burst();
    run_burst(8'h6B, "burst");
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL burst_done_pulse: done=%b busy=%b state=%b want 0 0 0", done, busy, dbg_state);
    end
  endtask

  task automatic test_burst_stall();
    logic [W-1:0] word = 8'hC5;
    d = word; start = 1'b1; sin_l = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      checks++;
      if (sout_lsb !== word[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_bit%0d: sout=%b busy=%b want sout=%b busy=1", i, sout_lsb, busy, word[i]);
      end
      if (i == 3) begin
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          checks++;
          if (sout_lsb !== word[3] || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL stall_freeze%0d: sout=%b busy=%b done=%b want sout=%b busy=1 done=0",
                     s, sout_lsb, busy, done, word[3]);
          end
        end
        en = 1'b1;
      end
      if (i == 5) begin
        start = 1'b1; mode = 3'b111; d = 8'hFF;
      end
      tick();
      start = 1'b0; mode = 3'b000;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h01) begin
      errors++;
      $display("FAIL stall_done: done=%b busy=%b q=%h want 1 0 01", done, busy, q);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || q !== 8'h01) begin
      errors++;
      $display("FAIL no_second_burst: busy=%b done=%b q=%h want 0 0 01", busy, done, q);
    end
  endtask

  task automatic test_back_to_back();
    run_burst(8'h0F, "b2b_first");
    d = 8'hF0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (q !== 8'hF0 || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back_start: q=%h busy=%b done=%b want f0 1 0", q, busy, done);
    end
    // Let the second burst drain.
    for (int i = 0; i < W; i++) tick();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_done: done=%b want 1", done);
    end
    tick();
  endtask

  task automatic test_async_reset();
    bit saw_done = 1'b0;
    d = 8'h6B; start = 1'b1; sin_l = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2 reset = 1'b0;
    #1;
    checks++;
    if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || dbg_state !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: q=%h busy=%b done=%b state=%b want 00 0 0 0", q, busy, done, dbg_state);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    #2 reset = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      tick();
      if (done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done seen=%b want 0", saw_done);
    end
    run_burst(8'h3C, "post_reset");
    tick();
  endtask

  initial begin
    test_reset();
    test_shift();
    test_rotate_asr_clear();
    test_burst();
    test_burst_stall();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
